pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter and picks the next fetch address each cycle:
//  sequential PC+4, PC-relative branch, pseudo-direct jump {PC[31:28],target,00},
//  or jump-register. Sits between decode/branch-resolve and the instruction
//  memory address port. Drives the pipeline flush and fetch-valid signals.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  FLUSH_CYCLES  1              bubble cycles after any redirect (1..7)
// PORTS
//  clk          in   1   rising-edge clock
//  resetn       in   1   asynchronous active-low reset
//  stall        in   1   hold PC (RUN state only)
//  br_taken     in   1   resolved taken branch this cycle
//  br_offset    in   16  signed word offset of the branch
//  jump         in   1   J/JAL this cycle
//  j_target     in   26  jump target field
//  jr           in   1   jump-register this cycle
//  jr_addr      in   32  register target address
//  halt         in   1   stop fetching until reset
//  pc           out  32  current fetch address
//  pc_plus4     out  32  pc + 4, mod 2^32 (combinational)
//  fetch_valid  out  1   pc is a valid fetch this cycle
//  flush        out  1   one-cycle pulse: kill younger instructions
//  align_err    out  1   one-cycle pulse: jr_addr[1:0] != 0
//  halted       out  1   block is in HALTED
// BEHAVIOUR
//  Reset (async, resetn=0): pc=RESET_PC, state=IDLE, fetch_valid=0, flush=0,
//   align_err=0, halted=0, flush counter=0. All outputs are registered except pc_plus4.
//  States: IDLE -> RUN (unconditional, next edge); RUN -> FLUSH on redirect;
//   FLUSH -> RUN when the counter reaches 0; RUN -> HALTED on halt; HALTED stays until reset.
//  fetch_valid=1 only in RUN. It drops to 0 in the cycle a stall is sampled.
//  RUN, per edge, in priority order:
//   1 halt=1: pc held, next state HALTED, all redirects dropped (halt applies even under stall).
//   2 stall=1: pc, state and counter held; redirect inputs ignored.
//   3 jr=1: pc <= {jr_addr[31:2],2'b00}; align_err=1 for one cycle if jr_addr[1:0]!=0.
//   4 jump=1: pc <= {pc[31:28], j_target, 2'b00} (upper bits from the current pc).
//   5 br_taken=1: pc <= pc + 4 + {{14{br_offset[15]}}, br_offset, 2'b00}, mod 2^32.
//   6 otherwise: pc <= pc + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
//  Cases 3-5 are redirects: flush=1 for exactly the next cycle, counter <= FLUSH_CYCLES,
//   state <= FLUSH.
//  FLUSH: pc held at the target, fetch_valid=0. The counter decrements each edge and the
//   block returns to RUN when the counter hits 0. stall and redirect inputs are ignored.
//  Back-to-back redirects: a second redirect is accepted only after returning to RUN.
//  Reset mid-FLUSH or in HALTED: immediate return to reset values.
//  All adders are 32-bit and discard the carry out; no overflow flag.
// TESTING
//  T1 reset, RESET_PC=0, 4 idle cycles -> pc 0,0,4,8; fetch_valid 0,1,1,1.
//  T2 pc=32'h0000_0010, br_taken=1, br_offset=16'hFFFE -> pc=32'h0000_000C,
//   flush pulse=1 cycle, fetch_valid=0 for FLUSH_CYCLES cycles.
//  T3 pc=32'hA000_0040, jump=1, j_target=26'h0000100 -> pc=32'hA000_0400.
//   Same cycle as br_taken=1 -> jump wins.
//  T4 jr=1, jr_addr=32'h0000_1003 -> pc=32'h0000_1000, align_err=1 for 1 cycle.
//   With stall=1 in the same cycle -> no change, no flush.
//  T5 pc=32'hFFFF_FFFC, no control -> pc=0. halt together with jump -> halted=1,
//   pc unchanged, no flush.
//  T6 resetn low during FLUSH -> pc=RESET_PC and flush=0 immediately. Resume normal
//   sequencing after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter owner. Each cycle it picks the next fetch address
//   (pc+4, PC-relative branch, pseudo-direct jump or jump-register) and
//   drives the pipeline flush and fetch-valid qualifiers.
//
//   Ports
//     clk, resetn          clock, asynchronous active-low reset
//     stall                hold pc (RUN only)
//     br_taken, br_offset  resolved taken branch, signed word offset
//     jump, j_target       J/JAL, 26-bit target field
//     jr, jr_addr          jump-register and its target
//     halt                 stop fetching until reset
//     pc, pc_plus4         fetch address and its +4 (combinational)
//     fetch_valid          pc is a valid fetch this cycle
//     flush                one-cycle pulse after a redirect
//     align_err            one-cycle pulse for a misaligned jr target
//     halted               block sits in HALTED
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   S_IDLE   | first cycle after reset, pc = RESET_PC, no fetch
//   S_RUN    | normal sequencing, redirects accepted
//   S_FLUSH  | pc parked on redirect target, bubbles counting down
//   S_HALTED | fetch stopped, left only by reset
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] j_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        align_err,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALTED} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] br_target;
  logic [31:0] j_addr;
  logic        redirect;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign j_addr    = {pc[31:28], j_target, 2'b00};
  assign redirect  = jr | jump | br_taken;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      cnt         <= 3'd0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      align_err   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      flush     <= 1'b0;
      align_err <= 1'b0;
      case (state)
        S_IDLE: begin
          state       <= S_RUN;
          fetch_valid <= 1'b1;
        end
        S_RUN: begin
          if (halt) begin
            state       <= S_HALTED;
            halted      <= 1'b1;
            fetch_valid <= 1'b0;
          end else if (stall) begin
            fetch_valid <= 1'b0;
          end else if (redirect) begin
            state       <= S_FLUSH;
            cnt         <= FLUSH_LOAD;
            flush       <= 1'b1;
            fetch_valid <= 1'b0;
            if (jr) begin
              pc        <= {jr_addr[31:2], 2'b00};
              align_err <= |jr_addr[1:0];
            end else if (jump) begin
              pc <= j_addr;
            end else begin
              pc <= br_target;
            end
          end else begin
            pc          <= pc_plus4;
            fetch_valid <= 1'b1;
          end
        end
        S_FLUSH: begin
          cnt <= cnt - 3'd1;
          // Counter reaching zero on this edge ends the bubble train.
          if (cnt <= 3'd1) begin
            state       <= S_RUN;
            fetch_valid <= 1'b1;
          end
        end
        S_HALTED: begin
          fetch_valid <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0, jr = 1'b0, halt = 1'b0;
  logic [15:0] br_offset = '0;
  logic [25:0] j_target = '0;
  logic [31:0] jr_addr = '0;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, flush, align_err, halted;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: behavioural view of the sequencer
  logic [31:0] m_pc;
  logic        m_fv, m_flush, m_align, m_halted, m_started;
  int          m_bub;

  pc_sequencer #(.RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .jump(jump), .j_target(j_target), .jr(jr),
    .jr_addr(jr_addr), .halt(halt), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush(flush), .align_err(align_err),
    .halted(halted));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_fv = 0; m_flush = 0; m_align = 0; m_halted = 0;
    m_started = 0; m_bub = 0;
  endtask

  task automatic model_edge();
    int off;
    m_flush = 0; m_align = 0;
    if (!m_started) begin
      m_started = 1; m_fv = 1;
    end else if (m_halted) begin
      m_fv = 0;
    end else if (m_bub > 0) begin
      m_bub = m_bub - 1;
      m_fv = (m_bub == 0);
    end else if (halt) begin
      m_halted = 1; m_fv = 0;
    end else if (stall) begin
      m_fv = 0;
    end else if (jr || jump || br_taken) begin
      if (jr) begin
        m_pc = jr_addr & 32'hFFFF_FFFC;
        m_align = (jr_addr % 4) != 0;
      end else if (jump) begin
        m_pc = (m_pc & 32'hF000_0000) | (32'(j_target) << 2);
      end else begin
        off = $signed(br_offset);
        m_pc = m_pc + 32'd4 + 32'(off * 4);
      end
      m_flush = 1; m_fv = 0; m_bub = FC;
    end else begin
      m_pc = m_pc + 32'd4; m_fv = 1;
    end
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; jump = 0; jr = 0; halt = 0;
    br_offset = '0; j_target = '0; jr_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0; model_reset();
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    resetn = 0; model_reset();
    #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
    n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_align: got %b expected 0", align_err); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    @(negedge clk);
    resetn = 1;
    tick();
    n_checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq0: got pc %h fv %b expected 0 1", pc, fetch_valid); end
    tick();
    n_checks++; if (pc !== 32'h4 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq1: got pc %h fv %b expected 4 1", pc, fetch_valid); end
    tick();
    n_checks++; if (pc !== 32'h8 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq2: got pc %h fv %b expected 8 1", pc, fetch_valid); end
    n_checks++; if (pc_plus4 !== 32'hC) begin n_fail++; $display("FAIL seq_plus4: got %h expected %h", pc_plus4, 32'hC); end
  endtask

  task automatic test_branch();
    jr = 1; jr_addr = 32'h10; tick(); clear_inputs();
    repeat (FC) tick();
    n_checks++; if (pc !== 32'h10 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL br_setup: got pc %h fv %b expected 10 1", pc, fetch_valid); end
    br_taken = 1; br_offset = 16'hFFFE; tick(); clear_inputs();
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL br_pc: got %h expected %h", pc, 32'hC); end
    n_checks++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush: got flush %b fv %b expected 1 0", flush, fetch_valid); end
    for (int i = 1; i < FC; i++) begin
      tick();
      n_checks++; if (flush !== 1'b0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble: got flush %b fv %b expected 0 0", flush, fetch_valid); end
    end
    tick();
    n_checks++; if (fetch_valid !== 1'b1 || flush !== 1'b0 || pc !== 32'hC) begin n_fail++; $display("FAIL br_resume: got fv %b flush %b pc %h expected 1 0 c", fetch_valid, flush, pc); end
  endtask

  task automatic test_jump();
    jr = 1; jr_addr = 32'hA000_0040; tick(); clear_inputs();
    repeat (FC) tick();
    jump = 1; j_target = 26'h0000100; br_taken = 1; br_offset = 16'h0010;
    tick(); clear_inputs();
    n_checks++; if (pc !== 32'hA000_0400) begin n_fail++; $display("FAIL jump_pc: got %h expected %h", pc, 32'hA000_0400); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush: got %b expected 1", flush); end
    repeat (FC) tick();
  endtask

  task automatic test_jr();
    stall = 1; jr = 1; jr_addr = 32'h0000_1003; tick();
    n_checks++; if (pc !== 32'hA000_0400 || flush !== 1'b0 || align_err !== 1'b0) begin n_fail++; $display("FAIL jr_stall: got pc %h flush %b align %b expected a0000400 0 0", pc, flush, align_err); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL jr_stall_fv: got %b expected 0", fetch_valid); end
    stall = 0; tick(); clear_inputs();
    n_checks++; if (pc !== 32'h1000 || align_err !== 1'b1 || flush !== 1'b1) begin n_fail++; $display("FAIL jr_pc: got pc %h align %b flush %b expected 1000 1 1", pc, align_err, flush); end
    tick();
    n_checks++; if (align_err !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL jr_pulse: got align %b flush %b expected 0 0", align_err, flush); end
    repeat (FC - 1) tick();
  endtask

  task automatic test_wrap_halt();
    jr = 1; jr_addr = 32'hFFFF_FFFC; tick(); clear_inputs();
    repeat (FC) tick();
    n_checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_setup: got pc %h plus4 %h expected fffffffc 0", pc, pc_plus4); end
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", pc); end
    tick();
    halt = 1; jump = 1; j_target = 26'h3FF_FFFF; tick(); clear_inputs();
    n_checks++; if (halted !== 1'b1 || pc !== 32'h4 || flush !== 1'b0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt: got halted %b pc %h flush %b fv %b expected 1 4 0 0", halted, pc, flush, fetch_valid); end
    jr = 1; jr_addr = 32'h100; repeat (3) tick(); clear_inputs();
    n_checks++; if (halted !== 1'b1 || pc !== 32'h4 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got halted %b pc %h fv %b expected 1 4 0", halted, pc, fetch_valid); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    tick();
    jr = 1; jr_addr = 32'h200; tick(); clear_inputs();
    n_checks++; if (flush !== 1'b1 || pc !== 32'h200) begin n_fail++; $display("FAIL rf_setup: got flush %b pc %h expected 1 200", flush, pc); end
    #2 resetn = 0; model_reset();
    #1;
    n_checks++; if (pc !== 32'h0 || flush !== 1'b0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rf_async: got pc %h flush %b fv %b expected 0 0 0", pc, flush, fetch_valid); end
    @(negedge clk); resetn = 1;
    tick(); tick();
    n_checks++; if (pc !== 32'h4 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rf_resume: got pc %h fv %b expected 4 1", pc, fetch_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        clear_inputs();
        do_reset();
      end
      stall     = ($urandom_range(0, 3) == 0);
      jr        = ($urandom_range(0, 7) == 0);
      jump      = ($urandom_range(0, 7) == 0);
      br_taken  = ($urandom_range(0, 5) == 0);
      halt      = ($urandom_range(0, 59) == 0);
      br_offset = 16'($urandom_range(0, 65535));
      j_target  = 26'($urandom);
      jr_addr   = $urandom;
      tick();
      n_checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || fetch_valid !== m_fv ||
          flush !== m_flush || align_err !== m_align || halted !== m_halted) begin
        n_fail++;
        $display("FAIL rand_%0d: got pc %h p4 %h fv %b fl %b al %b h %b expected pc %h p4 %h fv %b fl %b al %b h %b",
                 i, pc, pc_plus4, fetch_valid, flush, align_err, halted,
                 m_pc, m_pc + 32'd4, m_fv, m_flush, m_align, m_halted);
      end
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branch();
    test_jump();
    test_jr();
    test_wrap_halt();
    test_reset_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
